// File: rtl/mac_serie.sv
// Serial multiply-accumulate FIR stage: one tap product per clock,
// result clamped to the signed word width expected by the rounding stage.
module mac_serie #(
  parameter int N_TAPS = 4,
  parameter int DW     = 6,
  parameter int OW     = 11,
  parameter int AW     = 14,
  localparam int IW    = $clog2(N_TAPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic signed [DW-1:0] x_in,
  input  logic                 coef_we,
  input  logic [IW-1:0]        coef_addr,
  input  logic signed [DW-1:0] coef_data,
  output logic signed [OW-1:0] y_out,
  output logic                 valid,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_e;

  localparam logic signed [AW-1:0] YMAX =
    AW'(2 ** (OW - 1) - 1);
  localparam logic signed [AW-1:0] YMIN =
    AW'(-(2 ** (OW - 1)));

  state_e state_q, state_d;

  logic signed [DW-1:0] x_q [N_TAPS];
  logic signed [DW-1:0] x_d [N_TAPS];
  logic signed [DW-1:0] c_q [N_TAPS];
  logic signed [DW-1:0] c_d [N_TAPS];

  logic signed [AW-1:0] acc_q, acc_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic signed [OW-1:0] y_q, y_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_ext;
  logic                   last;

  assign prod     = x_q[idx_q] * c_q[idx_q];
  assign prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
  assign last     = (idx_q == IW'(N_TAPS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = MAC;
      MAC:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d     = x_q;
    c_d     = c_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    y_d     = y_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        // write and start in the same cycle: the new
        // coefficient is already in place for this sum
        if (coef_we) c_d[coef_addr] = coef_data;
        if (start) begin
          x_d[0] = x_in;
          for (int i = 1; i < N_TAPS; i++)
            x_d[i] = x_q[i-1];
          acc_d  = '0;
          idx_d  = '0;
          busy_d = 1'b1;
        end
      end
      MAC: begin
        acc_d = acc_q + prod_ext;
        idx_d = idx_q + IW'(1);
      end
      DONE: begin
        if (acc_q > YMAX)
          y_d = YMAX[OW-1:0];
        else if (acc_q < YMIN)
          y_d = YMIN[OW-1:0];
        else
          y_d = acc_q[OW-1:0];
        valid_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_TAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
      acc_q   <= '0;
      idx_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign y_out = y_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mac_serie.sv
// Bench for mac_serie: table vectors and hand sequences,
// results matched against a scoreboard queue as valid pulses.
module tb_mac_serie;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic signed [5:0] x_in = '0;
  logic              coef_we = 1'b0;
  logic [1:0]        coef_addr = '0;
  logic signed [5:0] coef_data = '0;
  logic signed [10:0] y_out;
  logic              valid;
  logic              busy;

  mac_serie dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x_in      (x_in),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .y_out     (y_out),
    .valid     (valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
  } vec_t;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int n_results = 0;
  int exp_q[$];
  int lat_q[$];
  int mx[4];
  int mc[4];

  task automatic check(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        check("y_out", int'(y_out), exp_q.pop_front());
        check("latency", cyc - lat_q.pop_front(), 5);
      end
      n_results++;
    end
  end

  function automatic int model_step(int x);
    int s;
    for (int i = 3; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = x;
    s = 0;
    for (int i = 0; i < 4; i++) s += mx[i] * mc[i];
    if (s > 1023) s = 1023;
    if (s < -1024) s = -1024;
    return s;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mx[i] = 0;
      mc[i] = 0;
    end
    exp_q.delete();
    lat_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic write_coef(int a, int d);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = 2'(a);
    coef_data = 6'(d);
    @(negedge clk);
    coef_we = 1'b0;
    mc[a] = d;
  endtask

  task automatic launch(int x, int e);
    @(negedge clk);
    start = 1'b1;
    x_in  = 6'(x);
    exp_q.push_back(e);
    lat_q.push_back(cyc + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result(int target);
    for (int k = 0; k < 20; k++) begin
      if (n_results >= target) break;
      @(posedge clk);
    end
    check("result_arrived", int'(n_results >= target), 1);
  endtask

  vec_t tab3[4];
  vec_t tab4[8];

  initial begin
    int e;
    int n0;
    tab3[0] = '{1, 1};
    tab3[1] = '{2, 4};
    tab3[2] = '{3, 10};
    tab3[3] = '{4, 20};
    tab4[0] = '{31, 1023};
    tab4[1] = '{31, 1023};
    tab4[2] = '{31, 1023};
    tab4[3] = '{31, 1023};
    tab4[4] = '{-32, 1023};
    tab4[5] = '{-32, -62};
    tab4[6] = '{-32, -1024};
    tab4[7] = '{-32, -1024};

    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_y", int'(y_out), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);

    // zero coefficients, busy window E0..E4
    e = model_step(5);
    launch(5, e);
    for (int k = 0; k < 5; k++) begin
      check("busy_high", int'(busy), 1);
      if (k < 4) @(negedge clk);
    end
    @(negedge clk);
    check("busy_low_at_valid", int'(busy), 0);
    check("valid_high", int'(valid), 1);
    wait_result(1);
    @(negedge clk);
    check("valid_one_cycle", int'(valid), 0);

    write_coef(0, 1);
    e = model_step(5);
    launch(5, e);
    wait_result(2);

    do_reset();
    for (int a = 0; a < 4; a++) write_coef(a, a + 1);
    for (int i = 0; i < 4; i++) begin
      void'(model_step(tab3[i].x));
      n0 = n_results;
      launch(tab3[i].x, tab3[i].y);
      wait_result(n0 + 1);
    end

    for (int a = 0; a < 4; a++) write_coef(a, 31);
    for (int i = 0; i < 8; i++) begin
      void'(model_step(tab4[i].x));
      n0 = n_results;
      launch(tab4[i].x, tab4[i].y);
      wait_result(n0 + 1);
    end

    // start and coef write during MAC are both dropped
    n0 = n_results;
    e = model_step(3);
    launch(3, e);
    start     = 1'b1;
    x_in      = 6'sd9;
    coef_we   = 1'b1;
    coef_addr = 2'd0;
    coef_data = -6'sd5;
    @(negedge clk);
    start   = 1'b0;
    coef_we = 1'b0;
    wait_result(n0 + 1);
    repeat (8) @(negedge clk);
    check("single_result", n_results, n0 + 1);
    for (int a = 1; a < 4; a++) write_coef(a, 0);
    e = model_step(5);
    launch(5, e);
    wait_result(n0 + 2);

    // start in the valid cycle is accepted
    n0 = n_results;
    e = model_step(1);
    launch(1, e);
    repeat (4) @(negedge clk);
    e = model_step(2);
    launch(2, e);
    wait_result(n0 + 2);

    // reset mid-computation
    n0 = n_results;
    e = model_step(7);
    launch(7, e);
    reset = 1'b1;
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(valid), 0);
    check("abort_y", int'(y_out), 0);
    repeat (8) @(negedge clk);
    check("no_result_after_abort", n_results, n0);
    e = model_step(5);
    launch(5, e);
    wait_result(n0 + 1);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
